// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11/DHT22 single-wire reader.
package dht_pkg;

   localparam int FRAME_W = 40;

   localparam int DEF_CLK_HZ        = 100_000_000;
   localparam int DEF_POLL_MS       = 2000;
   localparam int DEF_START_US      = 18000;
   localparam int DEF_TIMEOUT_US    = 200;
   localparam int DEF_BIT_THRESH_US = 50;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_ACK,
      ST_ACK_LOW,
      ST_ACK_HIGH,
      ST_BIT_LOW,
      ST_BIT_HIGH,
      ST_CHECK
   } dht_state_e;

   // Modulo-256 sum of the four payload bytes; must equal the trailing byte.
   function automatic logic [7:0] frame_sum(input logic [FRAME_W-1:0] f);
      logic [7:0] s;
      s = f[39:32] + f[31:24];
      s = s + f[23:16];
      s = s + f[15:8];
      return s;
   endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Microsecond prescaler: one-clock pulse every CLK_HZ/1e6 clocks.
module dht_us_tick #(
   parameter int CLK_HZ = dht_pkg::DEF_CLK_HZ
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic us_tick_o
);

   localparam int RELOAD = CLK_HZ / 1_000_000 - 1;
   localparam int CW     = (RELOAD > 0) ? $clog2(RELOAD + 1) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Down-counter reloads at terminal count zero, which is also the tick.
   always_comb begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
         cnt_d = CW'(RELOAD);
      end
   end

   // Prescaler register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign us_tick_o = (cnt_q == '0);

endmodule

// File: rtl/dht_reader.sv
// DHT11/DHT22 single-wire master: periodic start pulse, response timing,
// 40-bit capture and checksum, publishing good frames on dth_data.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | pin released, waiting POLL_MS before the next transaction
// ST_START    | host drives the pin low for START_US
// ST_WAIT_ACK | pin released, waiting for the sensor to pull low
// ST_ACK_LOW  | sensor acknowledge low phase, waiting for rise
// ST_ACK_HIGH | sensor acknowledge high phase, waiting for fall
// ST_BIT_LOW  | bit preamble low, waiting for rise
// ST_BIT_HIGH | bit high phase being timed, fall shifts in one bit
// ST_CHECK    | all bits captured, checksum evaluated this cycle
module dht_reader
   import dht_pkg::*;
#(
   parameter int CLK_HZ        = DEF_CLK_HZ,
   parameter int POLL_MS       = DEF_POLL_MS,
   parameter int START_US      = DEF_START_US,
   parameter int TIMEOUT_US    = DEF_TIMEOUT_US,
   parameter int BIT_THRESH_US = DEF_BIT_THRESH_US
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dht_in,
   output logic               dht_oe,
   output logic [FRAME_W-1:0] dth_data,
   output logic               data_valid,
   output logic               crc_err,
   output logic               timeout_err,
   output logic               busy
);

   localparam logic [15:0] START_TC   = 16'(START_US);
   localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_US);
   localparam logic [15:0] BIT_TC     = 16'(BIT_THRESH_US);
   localparam logic [15:0] POLL_TC    = 16'(POLL_MS);
   localparam logic [9:0]  MS_TC      = 10'd999;
   localparam logic [5:0]  LAST_BIT   = 6'(FRAME_W - 1);

   logic us_tick;

   dht_us_tick #(
      .CLK_HZ (CLK_HZ)
   ) u_us_tick (
      .clk_i     (clk),
      .rst_ni    (rst),
      .us_tick_o (us_tick)
   );

   logic sync1_q, sync2_q, prev_q;
   logic pin_rise, pin_fall;

   // Two-flop synchronizer plus a delayed copy for edge detection; idles high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= dht_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pin_rise = sync2_q & ~prev_q;
   assign pin_fall = ~sync2_q & prev_q;

   dht_state_e         state_q, state_d;
   logic [15:0]        us_cnt_q, us_cnt_d, us_elapsed;
   logic [9:0]         sub_us_q;
   logic [15:0]        ms_cnt_q;
   logic [FRAME_W-1:0] shift_q;
   logic [5:0]         bit_cnt_q;
   logic               shift_en, to_evt, tmo, bit_val, idle_done;
   logic               enter_idle, enter_start, sum_ok;

   // Elapsed microseconds in the current state including this cycle's tick,
   // so a high phase of exactly N us measures as N.
   assign us_elapsed = us_cnt_q + {15'd0, us_tick};
   assign tmo        = (us_elapsed >= TIMEOUT_TC);
   assign bit_val    = (us_elapsed >= BIT_TC);
   assign idle_done  = (ms_cnt_q == POLL_TC);
   assign sum_ok     = (frame_sum(shift_q) == shift_q[7:0]);

   // Next-state logic; a detected edge wins over a timeout in the same cycle.
   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      to_evt   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (idle_done) state_d = ST_START;
         end
         ST_START: begin
            if (us_elapsed >= START_TC) state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (pin_fall) begin
               state_d = ST_ACK_LOW;
            end else if (tmo) begin
               to_evt  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ACK_LOW: begin
            if (pin_rise) begin
               state_d = ST_ACK_HIGH;
            end else if (tmo) begin
               to_evt  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ACK_HIGH: begin
            if (pin_fall) begin
               state_d = ST_BIT_LOW;
            end else if (tmo) begin
               to_evt  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_BIT_LOW: begin
            if (pin_rise) begin
               state_d = ST_BIT_HIGH;
            end else if (tmo) begin
               to_evt  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_BIT_HIGH: begin
            if (pin_fall) begin
               shift_en = 1'b1;
               state_d  = (bit_cnt_q == LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
            end else if (tmo) begin
               to_evt  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign enter_idle  = (state_d == ST_IDLE)  && (state_q != ST_IDLE);
   assign enter_start = (state_d == ST_START) && (state_q != ST_START);
   assign us_cnt_d    = (state_d != state_q) ? 16'd0 : us_elapsed;

   // Per-state microsecond counter, cleared on every state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         us_cnt_q <= '0;
      end else begin
         us_cnt_q <= us_cnt_d;
      end
   end

   // Idle poll timer: microsecond-in-ms counter feeding a ms counter,
   // restarted on every return to IDLE so retries use the same period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sub_us_q <= '0;
         ms_cnt_q <= '0;
      end else if (enter_idle) begin
         sub_us_q <= '0;
         ms_cnt_q <= '0;
      end else if ((state_q == ST_IDLE) && us_tick) begin
         if (sub_us_q == MS_TC) begin
            sub_us_q <= '0;
            ms_cnt_q <= ms_cnt_q + 16'd1;
         end else begin
            sub_us_q <= sub_us_q + 10'd1;
         end
      end
   end

   // Bit capture: MSB-first shift, cleared at the start of each transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (enter_start) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (shift_en) begin
         shift_q   <= {shift_q[FRAME_W-2:0], bit_val};
         bit_cnt_q <= bit_cnt_q + 6'd1;
      end
   end

   // Registered outputs: pin driver and result pulses land with the IDLE entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dht_oe      <= 1'b0;
         dth_data    <= '0;
         data_valid  <= 1'b0;
         crc_err     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         dht_oe      <= (state_d == ST_START);
         data_valid  <= (state_q == ST_CHECK) && sum_ok;
         crc_err     <= (state_q == ST_CHECK) && !sum_ok;
         timeout_err <= to_evt;
         if ((state_q == ST_CHECK) && sum_ok) begin
            dth_data <= shift_q;
         end
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dht_reader.sv
// Bench for dht_reader: behavioural sensor on an open-drain pin model,
// scaled to a 1 MHz clock so one microsecond is one clock.
`timescale 1ns/1ps
module tb_dht_reader;

   localparam int CLK_HZ     = 1_000_000;
   localparam int POLL_MS    = 2;
   localparam int START_US   = 500;
   localparam int TIMEOUT_US = 200;
   localparam int THRESH     = 50;
   localparam int POLL_CYC   = POLL_MS * 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        sensor_low;
   logic        dht_in;
   logic        dht_oe;
   logic [39:0] dth_data;
   logic        data_valid, crc_err, timeout_err, busy;

   assign dht_in = ~(dht_oe | sensor_low);

   always #500 clk = ~clk;

   dht_reader #(
      .CLK_HZ        (CLK_HZ),
      .POLL_MS       (POLL_MS),
      .START_US      (START_US),
      .TIMEOUT_US    (TIMEOUT_US),
      .BIT_THRESH_US (THRESH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dht_in      (dht_in),
      .dht_oe      (dht_oe),
      .dth_data    (dth_data),
      .data_valid  (data_valid),
      .crc_err     (crc_err),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   int          n_valid = 0, n_crc = 0, n_to = 0, end_cyc = 0, stable_viol = 0;
   logic        pulse_busy = 1'b0, pulse_prev_busy = 1'b0, busy_prev = 1'b0;
   logic [39:0] pulse_data = '0, data_prev = '0;

   always @(negedge clk) begin
      if (rst) begin
         if (data_valid || crc_err || timeout_err) begin
            end_cyc         = cyc;
            pulse_busy      = busy;
            pulse_prev_busy = busy_prev;
            pulse_data      = dth_data;
         end
         if (data_valid)  n_valid++;
         if (crc_err)     n_crc++;
         if (timeout_err) n_to++;
         if (!data_valid && (dth_data !== data_prev)) stable_viol++;
      end
      data_prev = dth_data;
      busy_prev = busy;
   end

   int          hw[40];
   logic [39:0] exp_data = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      n_vec++;
      assert (obs >= lo && obs <= hi) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_oe(input logic lvl, input int max_cyc, input string tag, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < max_cyc) begin
         @(negedge clk);
         if (dht_oe === lvl) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: dht_oe did not reach %0b within %0d cycles", tag, lvl, max_cyc);
      end
   endtask

   // Start pulse: gap from the reference point, then the low-pulse width.
   task automatic do_start(input int ref_cyc, input string tag, output bit ok);
      int t_rise;
      wait_oe(1'b1, POLL_CYC + 100, {tag, "_start"}, ok);
      if (!ok) return;
      chk_rng({tag, "_gap"}, cyc - ref_cyc, POLL_CYC - 2, POLL_CYC + 5);
      t_rise = cyc;
      wait_oe(1'b0, START_US + 100, {tag, "_release"}, ok);
      if (!ok) return;
      chk_rng({tag, "_oe_width"}, cyc - t_rise, START_US - 1, START_US + 1);
   endtask

   // Sensor: 30 us turnaround, 80/80 ack, per bit 50 us low then hw[i] high.
   task automatic sensor_frame(input int abort_at);
      @(posedge clk);
      #1;
      sensor_low = 1'b0; hold(30);
      sensor_low = 1'b1; hold(80);
      sensor_low = 1'b0; hold(80);
      for (int i = 0; i < 40; i++) begin
         sensor_low = 1'b1; hold(50);
         sensor_low = 1'b0;
         if (i == abort_at) begin
            hold(10);
            return;
         end
         hold(hw[i]);
      end
      sensor_low = 1'b1; hold(50);
      sensor_low = 1'b0;
   endtask

   task automatic fill_widths(input logic [39:0] f);
      for (int i = 0; i < 40; i++) begin
         hw[i] = f[39-i] ? int'($urandom_range(60, 75)) : int'($urandom_range(20, 35));
      end
   endtask

   // Reference: a bit is 1 when its high phase lasts at least THRESH us.
   function automatic logic [39:0] decode_widths();
      logic [39:0] d;
      for (int i = 0; i < 40; i++) d[39-i] = (hw[i] >= THRESH);
      return d;
   endfunction

   function automatic bit sum_ok(input logic [39:0] f);
      int s;
      s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
      return (s % 256) == int'(f[7:0]);
   endfunction

   task automatic transaction(input string tag, input logic [39:0] f, input int ref_cyc,
                              input bit boundary);
      bit          ok, good;
      logic [39:0] dec;
      int          v0, c0, t0;
      fill_widths(f);
      if (boundary) begin
         hw[0] = THRESH - 1;
         hw[1] = THRESH;
      end
      dec  = decode_widths();
      good = sum_ok(dec);
      v0 = n_valid; c0 = n_crc; t0 = n_to;
      do_start(ref_cyc, tag, ok);
      if (!ok) return;
      sensor_frame(-1);
      hold(5);
      chk({tag, "_valid_cnt"}, 64'(n_valid - v0), good ? 64'd1 : 64'd0);
      chk({tag, "_crc_cnt"},   64'(n_crc - c0),   good ? 64'd0 : 64'd1);
      chk({tag, "_to_cnt"},    64'(n_to - t0),    64'd0);
      if (good) exp_data = dec;
      chk({tag, "_data"}, 64'(dth_data), 64'(exp_data));
      if (good) begin
         chk({tag, "_pulse_data"}, 64'(pulse_data), 64'(dec));
         chk({tag, "_busy_at_pulse"}, 64'(pulse_busy), 64'd0);
         chk({tag, "_busy_before"}, 64'(pulse_prev_busy), 64'd1);
      end
      chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
      chk({tag, "_oe_idle"}, 64'(dht_oe), 64'd0);
   endtask

   initial begin : main
      bit          ok;
      int          rel_cyc, t_rel, t0, n;
      logic [39:0] f;
      logic [7:0]  b4, b3, b2, b1;

      rst        = 1'b0;
      sensor_low = 1'b0;
      hold(5);
      @(negedge clk);
      chk("rst_oe",    64'(dht_oe),      64'd0);
      chk("rst_busy",  64'(busy),        64'd0);
      chk("rst_data",  64'(dth_data),    64'd0);
      chk("rst_valid", 64'(data_valid),  64'd0);
      chk("rst_crc",   64'(crc_err),     64'd0);
      chk("rst_to",    64'(timeout_err), 64'd0);
      @(posedge clk);
      #1;
      rst     = 1'b1;
      rel_cyc = cyc;

      transaction("good", 40'h3700190050, rel_cyc, 1'b0);
      transaction("bad_crc", 40'h3700190051, end_cyc, 1'b0);

      // Silent sensor: timeout after release, then retry after POLL_MS.
      t0 = n_to;
      do_start(end_cyc, "silent", ok);
      if (ok) begin
         t_rel = cyc;
         n = 0;
         while (n_to == t0 && n < TIMEOUT_US + 100) begin
            @(negedge clk);
            n++;
         end
         chk("silent_to_cnt", 64'(n_to - t0), 64'd1);
         chk_rng("silent_to_time", cyc - t_rel, TIMEOUT_US - 2, TIMEOUT_US + 3);
         chk("silent_oe", 64'(dht_oe), 64'd0);
         chk("silent_data", 64'(dth_data), 64'(exp_data));
      end

      transaction("boundary", 40'h4012340086, end_cyc, 1'b1);
      chk("boundary_bit39", 64'(dth_data[39]), 64'(hw[0] >= THRESH));
      chk("boundary_bit38", 64'(dth_data[38]), 64'(hw[1] >= THRESH));

      // Reset in the middle of bit 20.
      f = 40'h2A01150243;
      fill_widths(f);
      do_start(end_cyc, "abort", ok);
      if (ok) begin
         sensor_frame(20);
         rst = 1'b0;
         #1;
         chk("abort_oe",   64'(dht_oe),   64'd0);
         chk("abort_busy", 64'(busy),     64'd0);
         chk("abort_data", 64'(dth_data), 64'd0);
         exp_data = '0;
         hold(5);
         rst     = 1'b1;
         rel_cyc = cyc;
         transaction("after_rst", 40'h3700190050, rel_cyc, 1'b0);
      end

      for (int k = 0; k < 3; k++) begin
         b4 = 8'($urandom); b3 = 8'($urandom); b2 = 8'($urandom); b1 = 8'($urandom);
         f  = {b4, b3, b2, b1, 8'(b4 + b3 + b2 + b1)};
         if (k == 1) f[7:0] = f[7:0] ^ (8'h01 << $urandom_range(0, 7));
         transaction($sformatf("rand%0d", k), f, end_cyc, 1'b0);
      end

      chk("data_stability", 64'(stable_viol), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
